// File: rtl/cordic16_seq.sv
// cordic16_seq: transaction sequencer wrapped around one cordic16 datapath.
//
// A request angle is accepted over a valid/ready port. The sequencer then
// pulses cx_load with cx_addr=0, steps cx_addr through 1..NITER-1 on
// consecutive cycles, and captures cx_sin/cx_cos one cycle after the last
// iteration. The result is held on a valid/ready port until it is consumed.
//
// Ports
//   clock, reset_n         system clock; synchronous active-low reset
//   in_valid/in_ready      request handshake, in_angle is the requested angle
//   cx_endangle/addr/load  drive the cordic16 instance
//   cx_sin/cx_cos          cordic16 results
//   out_valid/out_ready    result handshake, out_sin/out_cos held while valid
//   busy                   high whenever the sequencer is not idle
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// LOAD  | cx_load=1, cx_addr=0 for one cycle
// ITER  | cx_addr steps 1..NITER-1
// CAPT  | cx_addr held at NITER-1, sin/cos captured at the end of the cycle
// DONE  | result presented until out_ready

module cordic16_seq #(
  parameter int WIDTH = 16,
  parameter int NITER = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_angle,
  output logic             in_ready,
  output logic [WIDTH-1:0] cx_endangle,
  output logic [AW-1:0]    cx_addr,
  output logic             cx_load,
  input  logic [WIDTH-1:0] cx_sin,
  input  logic [WIDTH-1:0] cx_cos,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sin,
  output logic [WIDTH-1:0] out_cos,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } state_t;

  // Exit is decided on an exact compare so that NITER = 2**AW never wraps
  // the counter into a second pass.
  localparam logic [AW-1:0] LAST_ADDR = AW'(NITER - 1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] cnt_nx;

  // cx_addr doubles as the iteration counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = cx_addr;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (in_valid) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = ITER;
        cnt_nx   = AW'(1);
      end
      ITER: begin
        if (cx_addr == LAST_ADDR) state_nx = CAPT;
        else                      cnt_nx   = cx_addr + AW'(1);
      end
      CAPT: state_nx = DONE;
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Handshake/strobe outputs are registered from the next state so they line
  // up with the state they describe without any combinational path.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      cx_load     <= 1'b0;
      cx_addr     <= '0;
      cx_endangle <= '0;
      out_valid   <= 1'b0;
      out_sin     <= '0;
      out_cos     <= '0;
    end else begin
      in_ready <= (state_nx == IDLE);
      busy     <= (state_nx != IDLE);
      cx_load  <= (state_nx == LOAD);
      cx_addr  <= cnt_nx;
      if (state == IDLE && in_valid) cx_endangle <= in_angle;
      if (state == CAPT) begin
        out_sin   <= cx_sin;
        out_cos   <= cx_cos;
        out_valid <= 1'b1;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic16_seq.sv
`timescale 1ns/1ps
module tb_cordic16_seq;
  localparam int WIDTH   = 16;
  localparam int NITER   = 16;
  localparam int AW      = 4;
  localparam int NITER_S = 4;
  localparam int AW_S    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, in_valid, in_ready, cx_load, out_valid, out_ready, busy;
  logic [WIDTH-1:0]  in_angle, cx_endangle, cx_sin, cx_cos, out_sin, out_cos;
  logic [AW-1:0]     cx_addr;

  logic              s_in_valid, s_in_ready, s_cx_load, s_out_valid, s_out_ready, s_busy;
  logic [WIDTH-1:0]  s_in_angle, s_cx_endangle, s_cx_sin, s_cx_cos, s_out_sin, s_out_cos;
  logic [AW_S-1:0]   s_cx_addr;

  cordic16_seq #(.WIDTH(WIDTH), .NITER(NITER), .AW(AW)) u_dut (
    .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_angle(in_angle),
    .in_ready(in_ready), .cx_endangle(cx_endangle), .cx_addr(cx_addr),
    .cx_load(cx_load), .cx_sin(cx_sin), .cx_cos(cx_cos), .out_valid(out_valid),
    .out_sin(out_sin), .out_cos(out_cos), .out_ready(out_ready), .busy(busy));

  cordic16_seq #(.WIDTH(WIDTH), .NITER(NITER_S), .AW(AW_S)) u_small (
    .clock(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_angle(s_in_angle),
    .in_ready(s_in_ready), .cx_endangle(s_cx_endangle), .cx_addr(s_cx_addr),
    .cx_load(s_cx_load), .cx_sin(s_cx_sin), .cx_cos(s_cx_cos), .out_valid(s_out_valid),
    .out_sin(s_out_sin), .out_cos(s_out_cos), .out_ready(s_out_ready), .busy(s_busy));

  // Stand-in datapath: value moves every cycle, so a capture taken on the
  // wrong edge produces a different number.
  logic [WIDTH-1:0] acc;
  always @(posedge clk) begin
    if (cx_load) acc <= cx_endangle;
    else         acc <= acc * 16'd3 + 16'(cx_addr);
  end
  assign cx_sin = acc;
  assign cx_cos = {acc[7:0], acc[15:8]} ^ 16'hA5C3;

  // Reference: load the angle, apply iterations 1..NITER-1, read the result.
  function automatic logic [WIDTH-1:0] ref_sin(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] v;
    v = a;
    for (int i = 1; i < NITER; i++) v = v * 16'd3 + 16'(i);
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] ref_cos(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] v;
    v = ref_sin(a);
    return {v[7:0], v[15:8]} ^ 16'hA5C3;
  endfunction

  typedef struct { logic [WIDTH-1:0] s; logic [WIDTH-1:0] c; } exp_t;
  exp_t exp_q[$];
  int   rise_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int loads = 0;
  int accepts = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1ns after each rising edge. ph is the index of the
  // current cycle counted from the accept edge (1 = cycle after accept).
  logic             p_in_ready = 1'b1;
  logic             p_out_valid = 1'b0;
  int               ph = 0;
  bit               done_st = 1'b0;
  logic [WIDTH-1:0] cur_angle, held_sin, held_cos;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (cx_load === 1'b1) loads++;
    if (!reset_n) begin
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_addr", 32'(cx_addr), 0);
      chk("rst_load", 32'(cx_load), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_endangle", 32'(cx_endangle), 0);
      chk("rst_out_sin", 32'(out_sin), 0);
      chk("rst_out_cos", 32'(out_cos), 0);
      exp_q.delete();
      ph = 0;
      done_st = 1'b0;
    end else if (done_st) begin
      chk("done_load", 32'(cx_load), 0);
      if (p_out_valid && out_ready) begin
        chk("consume_clears_valid", 32'(out_valid), 0);
        chk("consume_in_ready", 32'(in_ready), 1);
        chk("consume_busy", 32'(busy), 0);
        chk("consume_addr", 32'(cx_addr), 0);
        done_st = 1'b0;
        ph = 0;
      end else begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_sin", 32'(out_sin), 32'(held_sin));
        chk("hold_cos", 32'(out_cos), 32'(held_cos));
        chk("hold_in_ready", 32'(in_ready), 0);
        chk("hold_busy", 32'(busy), 1);
      end
    end else begin
      if (ph == 0 && in_valid && p_in_ready) begin
        exp_t e;
        e.s = ref_sin(in_angle);
        e.c = ref_cos(in_angle);
        exp_q.push_back(e);
        cur_angle = in_angle;
        accepts++;
        ph = 1;
      end
      if (ph == 0) begin
        chk("idle_load", 32'(cx_load), 0);
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_in_ready", 32'(in_ready), 1);
      end else if (ph <= NITER + 1) begin
        int ea;
        ea = (ph == 1) ? 0 : ((ph <= NITER) ? ph - 1 : NITER - 1);
        chk("op_load", 32'(cx_load), 32'(ph == 1));
        chk("op_addr", 32'(cx_addr), ea);
        chk("op_endangle", 32'(cx_endangle), 32'(cur_angle));
        chk("op_in_ready", 32'(in_ready), 0);
        chk("op_busy", 32'(busy), 1);
        chk("op_out_valid_early", 32'(out_valid), 0);
        ph++;
      end else begin
        chk("latency_out_valid", 32'(out_valid), 1);
        chk("result_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_sin", 32'(out_sin), 32'(e.s));
          chk("result_cos", 32'(out_cos), 32'(e.c));
        end
        rise_q.push_back(cyc);
        held_sin = out_sin;
        held_cos = out_cos;
        done_st = 1'b1;
      end
    end
    p_in_ready = in_ready;
    p_out_valid = out_valid;
  end

  // Called right after a falling edge; returns after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] a);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_angle = a;
    for (int n = 0; n < 400 && !got; n++) begin
      if (in_ready) got = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: angle %0h not accepted within 400 cycles", a);
    end
  endtask

  task automatic run_until_idle(input bit rnd);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end while ((busy !== 1'b0) && n < 400);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles", busy, n);
    end
    out_ready = 1'b1;
  endtask

  task automatic small_test();
    s_out_ready = 1'b0;
    s_in_angle  = 16'h0bad;
    s_in_valid  = 1'b1;
    s_cx_sin    = 16'h1000;
    s_cx_cos    = 16'h2000;
    for (int k = 1; k <= NITER_S + 2; k++) begin
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      if (k <= NITER_S + 1) begin
        int ea;
        ea = (k == 1) ? 0 : ((k <= NITER_S) ? k - 1 : NITER_S - 1);
        chk("small_load", 32'(s_cx_load), 32'(k == 1));
        chk("small_addr", 32'(s_cx_addr), ea);
        chk("small_endangle", 32'(s_cx_endangle), 32'h0bad);
        chk("small_valid_early", 32'(s_out_valid), 0);
      end else begin
        // captured value is the one presented during the CAPT cycle
        chk("small_latency_valid", 32'(s_out_valid), 1);
        chk("small_sin", 32'(s_out_sin), 32'h1000 + NITER_S + 1);
        chk("small_cos", 32'(s_out_cos), 32'h2000 + NITER_S + 1);
      end
      s_cx_sin = 16'(32'h1000 + k);
      s_cx_cos = 16'(32'h2000 + k);
    end
    @(posedge clk);
    #1;
    chk("small_hold_sin", 32'(s_out_sin), 32'h1000 + NITER_S + 1);
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("small_consume_valid", 32'(s_out_valid), 0);
    chk("small_consume_ready", 32'(s_in_ready), 1);
    @(negedge clk);
  endtask

  initial begin
    int l0, r0, n;
    reset_n = 1'b0; in_valid = 1'b0; in_angle = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_angle = '0; s_cx_sin = '0; s_cx_cos = '0; s_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // single operation
    send(16'h2500);
    run_until_idle(1'b0);

    // backpressure
    out_ready = 1'b0;
    send(16'h2500);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("bp_valid_seen", 32'(out_valid), 1);
    repeat (6) @(negedge clk);
    out_ready = 1'b1;
    run_until_idle(1'b0);

    // request held during an operation is ignored until idle
    l0 = loads;
    send(16'h2500);
    repeat (5) @(negedge clk);
    send(16'h2a72);
    run_until_idle(1'b0);
    chk("ignore_load_pulses", loads - l0, 2);

    // back-to-back
    l0 = loads;
    r0 = rise_q.size();
    send(16'h2500);
    send(16'h2a72);
    run_until_idle(1'b0);
    chk("b2b_loads", loads - l0, 2);
    chk("b2b_results", rise_q.size() - r0, 2);
    if (rise_q.size() >= r0 + 2)
      chk("b2b_spacing", rise_q[r0+1] - rise_q[r0], NITER + 3);

    // reset mid-operation
    r0 = rise_q.size();
    send(16'h3c3c);
    n = 0;
    while (cx_addr !== AW'(7) && n < 40) begin @(negedge clk); n++; end
    chk("midrst_addr_reached", 32'(cx_addr), 7);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_result", rise_q.size() - r0, 0);
    send(16'h2500);
    run_until_idle(1'b0);
    chk("midrst_fresh_result", rise_q.size() - r0, 1);

    // random angles with random backpressure
    repeat (20) begin
      send(16'($urandom));
      run_until_idle(1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    small_test();

    chk("total_load_pulses", loads, accepts);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic16_seq.md
Name: cordic16_seq

Overview:
- Sequencer that owns one cordic16 datapath and runs it as a transaction engine.
- Accepts an angle through a valid/ready request port, then drives cordic16's endangle/addr/load through the load step and all iteration steps.
- Captures cordic16's sin/cos once the last iteration completes and presents them on a valid/ready result port.
- Replaces hand-sequenced addr/load stimulus; sits between the angle producer and the cordic16 instance, all on one clock.

Parameters:
- WIDTH, 16, data width of angle, sin and cos.
- NITER, 16, CORDIC iterations per operation; must be ≤ 2**AW and ≥ 2.
- AW, 4, width of the cordic16 addr (iteration index) bus.

Ports:
- clock  in  1  system clock, shared with cordic16; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising clock edge.
- in_valid  in  1  request valid.
- in_angle  in  WIDTH  requested angle, same encoding as cordic16 endangle.
- in_ready  out  1  request accepted on an edge where in_valid & in_ready.
- cx_endangle  out  WIDTH  angle to cordic16 endangle.
- cx_addr  out  AW  iteration index to cordic16 addr.
- cx_load  out  1  load strobe to cordic16 load.
- cx_sin  in  WIDTH  cordic16 sin output.
- cx_cos  in  WIDTH  cordic16 cos output.
- out_valid  out  1  result valid.
- out_sin  out  WIDTH  captured sine.
- out_cos  out  WIDTH  captured cosine.
- out_ready  in  1  result consumed on an edge where out_valid & out_ready.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered; none combinationally depends on inputs except as stated for in_ready.
- Reset (reset_n=0 at an edge), effective from the next cycle:
  - state=IDLE, in_ready=1, cx_endangle=0, cx_addr=0, cx_load=0.
  - out_valid=0, out_sin=0, out_cos=0, busy=0, iteration counter=0.
  - Reset applies in any state, including mid-iteration and while out_valid is held. Any in-flight operation is dropped without producing a result.
- States and transitions:
  - IDLE: in_ready=1, cx_load=0, cx_addr=0. On in_valid=1, latch in_angle into cx_endangle and go to LOAD.
  - LOAD (1 cycle): cx_load=1, cx_addr=0, then go to ITER with counter=1.
  - ITER: cx_load=0, cx_addr=counter, counter increments each cycle. After the cycle with cx_addr=NITER-1, go to CAPT.
  - CAPT (1 cycle): cx_addr holds NITER-1, cx_load=0. At the edge, out_sin←cx_sin, out_cos←cx_cos, out_valid←1, then go to DONE.
  - DONE: out_valid=1 with out_sin/out_cos held stable. On out_ready=1, clear out_valid and go to IDLE.
- in_ready is 1 only in IDLE. in_valid in any other state is ignored and does not queue.
- No new request is accepted in the same edge as result consumption; the next accept is at the earliest one cycle later.
- cx_endangle stays stable from LOAD through CAPT and keeps its value in IDLE until the next accept.
- Timing, with accept at edge E:
  - Cycle after E: cx_load=1, cx_addr=0.
  - Following cycles: cx_addr = 1 … NITER-1.
  - CAPT occupies the cycle after that.
  - out_valid is first high NITER+2 cycles after E (18 at defaults).
- Back-to-back throughput is NITER+3 cycles per operation when out_ready is held high.
- cx_load is high for exactly one cycle per accepted request and never otherwise.
- The counter is AW bits wide. At NITER = 2**AW it must not wrap into a second pass; the transition to CAPT is decided on counter==NITER-1.
- out_valid, once set, stays high until consumed or reset. Result data must not change while out_valid=1.

Test Plan:
- Single op: reset_n=0 for 2 edges, then in_valid=1, in_angle=16'h2500 for one cycle, out_ready=1.
  - cx_load=1 with cx_addr=0 for exactly one cycle.
  - cx_addr then steps 1..15 on consecutive cycles, with cx_endangle=16'h2500 throughout.
  - out_valid rises 18 cycles after the accept edge.
  - out_sin/out_cos equal cx_sin/cx_cos sampled at the CAPT edge.
- Backpressure: out_ready=0 for 6 cycles after out_valid rises.
  - out_valid stays 1 and out_sin/out_cos stay constant.
  - in_ready=0 and busy=1 throughout.
  - Raising out_ready clears out_valid at the next edge, and in_ready=1 the following cycle.
- Busy-ignore: with angle 16'h2500 in flight, hold in_valid=1 with in_angle=16'h2a72 during ITER.
  - cx_endangle stays 16'h2500 and no second cx_load pulse appears.
  - 16'h2a72 is accepted only once IDLE is re-entered.
- Back-to-back: in_valid=1 held with angles 16'h2500 then 16'h2a72, out_ready=1.
  - Two results are produced, with out_valid pulses 19 cycles apart.
  - Exactly 2 cx_load pulses occur.
- Reset mid-op: assert reset_n=0 for 1 edge while cx_addr=7.
  - The next cycle shows IDLE values: in_ready=1, cx_addr=0, cx_load=0, out_valid=0, busy=0.
  - No result is produced for the aborted angle, and a fresh request afterwards completes normally in 18 cycles.
- NITER=4, AW=2 build:
  - cx_addr sequence is 0,1,2,3 with no wrap to 0 inside the operation.
  - out_valid rises 6 cycles after accept.
